// File: rtl/huffman_enc_param.sv
// Frame-based Huffman code generator. It counts symbols 1..NSYM over one gray_valid
// burst, then builds the codewords in NSYM-1 sequential min/second-min merge rounds.
module huffman_enc_param #(
  parameter int NSYM  = 6,
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int CODEW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gray_valid,
  input  logic [DW-1:0]         gray_data,
  output logic                  busy,
  output logic                  cnt_valid,
  output logic [NSYM*CW-1:0]    cnt,
  output logic                  code_valid,
  output logic [NSYM*CODEW-1:0] hc,
  output logic [NSYM*CODEW-1:0] m
);

  localparam int WW  = CW + $clog2(NSYM);  // weight width, wide enough for the sum of all counts
  localparam int IDW = $clog2(2 * NSYM);   // group ids reach 2*NSYM-2
  localparam int XW  = $clog2(NSYM);       // symbol index and round counter
  localparam int LW  = $clog2(CODEW + 1);

  typedef enum logic [2:0] {IDLE, READ, CNT_OUT, SCAN1, SCAN2, MERGE, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q [NSYM];
  logic [WW-1:0]    w_q   [NSYM];
  logic [IDW-1:0]   gid_q [NSYM];
  logic [LW-1:0]    len_q [NSYM];
  logic [CODEW-1:0] hc_q  [NSYM];
  logic [XW-1:0]    idx_q;
  logic [XW-1:0]    round_q;
  logic             found_q;
  logic [WW-1:0]    best_w_q, first_w_q, second_w_q;
  logic [IDW-1:0]   best_id_q, first_id_q, second_id_q;
  logic             busy_q, cnt_valid_q, code_valid_q;

  logic [NSYM-1:0]  hit;
  logic [WW-1:0]    cand_w;
  logic [IDW-1:0]   cand_id;
  logic             take;
  logic [WW-1:0]    pick_w_d;
  logic [IDW-1:0]   pick_id_d;
  logic             last_idx;
  logic [IDW-1:0]   new_id;
  logic [WW-1:0]    new_w;

  // Values 0 and >NSYM match no symbol, so they drop out here.
  always_comb begin
    for (int k = 0; k < NSYM; k++) hit[k] = (gray_data == DW'(k + 1));
  end

  // One symbol is compared per scan cycle. Ties go to the higher group id, and
  // SCAN2 skips every member of the group chosen in SCAN1.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; otherwise a latch is inferred.
    cand_w    = w_q[idx_q];
    cand_id   = gid_q[idx_q];
    take      = ((state_q == SCAN1) || (cand_id != first_id_q)) &&
                (!found_q || (cand_w < best_w_q) ||
                 ((cand_w == best_w_q) && (cand_id > best_id_q)));
    pick_w_d  = take ? cand_w  : best_w_q;
    pick_id_d = take ? cand_id : best_id_q;
  end

  assign last_idx = (idx_q == XW'(NSYM - 1));
  assign new_id   = IDW'(NSYM) + IDW'(round_q);
  assign new_w    = first_w_q + second_w_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the arrays are reset because cnt/hc/m must read 0 after reset; they are not RAMs.
      state_q      <= IDLE;
      idx_q        <= '0;
      round_q      <= '0;
      found_q      <= 1'b0;
      best_w_q     <= '0;
      best_id_q    <= '0;
      first_w_q    <= '0;
      first_id_q   <= '0;
      second_w_q   <= '0;
      second_id_q  <= '0;
      busy_q       <= 1'b0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      for (int k = 0; k < NSYM; k++) begin
        cnt_q[k] <= '0;
        w_q[k]   <= '0;
        gid_q[k] <= '0;
        len_q[k] <= '0;
        hc_q[k]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (gray_valid) begin
            for (int k = 0; k < NSYM; k++) begin
              cnt_q[k] <= CW'(hit[k]);
              hc_q[k]  <= '0;
              len_q[k] <= '0;
            end
            state_q <= READ;
          end
        end

        READ: begin
          if (gray_valid) begin
            for (int k = 0; k < NSYM; k++) begin
              if (hit[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
          end else begin
            cnt_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= CNT_OUT;
          end
        end

        CNT_OUT: begin
          cnt_valid_q <= 1'b0;
          for (int k = 0; k < NSYM; k++) begin
            w_q[k]   <= WW'(cnt_q[k]);
            gid_q[k] <= IDW'(k);
          end
          idx_q   <= '0;
          round_q <= '0;
          found_q <= 1'b0;
          state_q <= SCAN1;
        end

        SCAN1: begin
          best_w_q  <= pick_w_d;
          best_id_q <= pick_id_d;
          found_q   <= found_q | take;
          if (last_idx) begin
            first_w_q  <= pick_w_d;
            first_id_q <= pick_id_d;
            found_q    <= 1'b0;
            idx_q      <= '0;
            state_q    <= SCAN2;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        SCAN2: begin
          best_w_q  <= pick_w_d;
          best_id_q <= pick_id_d;
          found_q   <= found_q | take;
          if (last_idx) begin
            second_w_q  <= pick_w_d;
            second_id_q <= pick_id_d;
            found_q     <= 1'b0;
            idx_q       <= '0;
            state_q     <= MERGE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        MERGE: begin
          // Codes grow from the leaf upward: the new bit lands at position len.
          for (int k = 0; k < NSYM; k++) begin
            if (gid_q[k] == first_id_q) begin
              hc_q[k]  <= hc_q[k] | (CODEW'(1) << len_q[k]);
              len_q[k] <= len_q[k] + 1'b1;
              gid_q[k] <= new_id;
              w_q[k]   <= new_w;
            end else if (gid_q[k] == second_id_q) begin
              hc_q[k]  <= hc_q[k] & ~(CODEW'(1) << len_q[k]);
              len_q[k] <= len_q[k] + 1'b1;
              gid_q[k] <= new_id;
              w_q[k]   <= new_w;
            end
          end
          if (round_q == XW'(NSYM - 2)) begin
            code_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            round_q <= round_q + 1'b1;
            state_q <= SCAN1;
          end
        end

        DONE: begin
          code_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt = '0;
    hc  = '0;
    m   = '0;
    for (int k = 0; k < NSYM; k++) begin
      cnt[k*CW +: CW]      = cnt_q[k];
      hc[k*CODEW +: CODEW] = hc_q[k];
      m[k*CODEW +: CODEW]  = (CODEW'(1) << len_q[k]) - CODEW'(1);
    end
  end

  assign busy       = busy_q;
  assign cnt_valid  = cnt_valid_q;
  assign code_valid = code_valid_q;

endmodule
